// File: rtl/shift_sequencer.sv
// shift_sequencer: drives a pixel shifter with load/shift strobes
// from a one-word prefetch buffer at the line-latched colour depth.
module shift_sequencer (
    input  logic        dotclk_i,
    input  logic        reset_i,
    input  logic [1:0]  bpp_i,
    input  logic        active_i,
    input  logic [15:0] word_dat_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic        flush_i,
    input  logic        clr_underflow_i,
    output logic [15:0] dat_o,
    output logic        load_o,
    output logic        shift1_o,
    output logic        shift2_o,
    output logic        shift4_o,
    output logic        shift8_o,
    output logic        underflow_o
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] word_buf_q;
    logic        buf_full_q;
    logic [3:0]  pix_cnt_q;
    logic [1:0]  bpp_lat_q;
    logic [3:0]  ppw_m1;
    logic        line_on;
    logic        cnt_zero;
    logic        load_now;
    logic        accept;
    logic        uf_set;

    always_comb begin
        state_d = state_q;
        line_on = 1'b0;
        case (state_q)
            IDLE: begin
                line_on = active_i;
                if (active_i) state_d = RUN;
            end
            RUN: begin
                line_on = 1'b1;
                if (!active_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ppw_m1 = 4'd15;
        case (bpp_lat_q)
            2'b00:   ppw_m1 = 4'd15;
            2'b01:   ppw_m1 = 4'd7;
            2'b10:   ppw_m1 = 4'd3;
            default: ppw_m1 = 4'd1;
        endcase
    end

    assign cnt_zero     = (pix_cnt_q == 4'd0);
    assign load_now     = line_on & active_i & cnt_zero & buf_full_q;
    assign word_ready_o = ~flush_i & (~buf_full_q | load_now);
    assign accept       = word_valid_i & word_ready_o;
    assign uf_set       = active_i & cnt_zero & ~buf_full_q;

    always_ff @(posedge dotclk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge dotclk_i) begin
        if (reset_i) begin
            word_buf_q  <= 16'h0000;
            buf_full_q  <= 1'b0;
            pix_cnt_q   <= 4'd0;
            bpp_lat_q   <= 2'b00;
            dat_o       <= 16'h0000;
            load_o      <= 1'b0;
            shift1_o    <= 1'b0;
            shift2_o    <= 1'b0;
            shift4_o    <= 1'b0;
            shift8_o    <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            load_o   <= 1'b0;
            shift1_o <= 1'b0;
            shift2_o <= 1'b0;
            shift4_o <= 1'b0;
            shift8_o <= 1'b0;

            // depth only follows the input outside the visible line
            if (!active_i) bpp_lat_q <= bpp_i;

            if (!active_i) begin
                pix_cnt_q <= 4'd0;
            end else if (cnt_zero) begin
                load_o    <= 1'b1;
                pix_cnt_q <= ppw_m1;
                dat_o     <= buf_full_q ? word_buf_q : 16'h0000;
            end else begin
                pix_cnt_q <= pix_cnt_q - 4'd1;
                case (bpp_lat_q)
                    2'b00:   shift1_o <= 1'b1;
                    2'b01:   shift2_o <= 1'b1;
                    2'b10:   shift4_o <= 1'b1;
                    default: shift8_o <= 1'b1;
                endcase
            end

            if (flush_i) begin
                buf_full_q <= 1'b0;
            end else if (accept) begin
                word_buf_q <= word_dat_i;
                buf_full_q <= 1'b1;
            end else if (load_now) begin
                buf_full_q <= 1'b0;
            end

            if (uf_set)               underflow_o <= 1'b1;
            else if (clr_underflow_i) underflow_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed vector bench for shift_sequencer: a table of per-edge
// records plus hand sequences for depth, latch, flush and reset cases.
module tb_shift_sequencer;
    logic        clk;
    logic        reset_i;
    logic [1:0]  bpp_i;
    logic        active_i;
    logic [15:0] word_dat_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic        flush_i;
    logic        clr_underflow_i;
    logic [15:0] dat_o;
    logic        load_o;
    logic        shift1_o;
    logic        shift2_o;
    logic        shift4_o;
    logic        shift8_o;
    logic        underflow_o;
    logic [3:0]  sh;

    int n_vec = 0;
    int n_bad = 0;

    shift_sequencer dut (
        .dotclk_i       (clk),
        .reset_i        (reset_i),
        .bpp_i          (bpp_i),
        .active_i       (active_i),
        .word_dat_i     (word_dat_i),
        .word_valid_i   (word_valid_i),
        .word_ready_o   (word_ready_o),
        .flush_i        (flush_i),
        .clr_underflow_i(clr_underflow_i),
        .dat_o          (dat_o),
        .load_o         (load_o),
        .shift1_o       (shift1_o),
        .shift2_o       (shift2_o),
        .shift4_o       (shift4_o),
        .shift8_o       (shift8_o),
        .underflow_o    (underflow_o)
    );

    assign sh = {shift8_o, shift4_o, shift2_o, shift1_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [1:0]  bpp;
        logic        act;
        logic        vld;
        logic [15:0] wd;
        logic        fl;
        logic        clr;
        logic        chk_rdy;
        logic        rdy;
        logic        ld;
        logic [3:0]  sh;
        logic [15:0] dat;
        logic        uf;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic [1:0] bpp,
        input logic act, input logic vld,
        input logic [15:0] wd, input logic fl,
        input logic clr, input logic chk_rdy,
        input logic rdy, input logic ld,
        input logic [3:0] s, input logic [15:0] dat,
        input logic uf);
        vec_t v;
        v.rst = rst; v.bpp = bpp; v.act = act;
        v.vld = vld; v.wd = wd; v.fl = fl;
        v.clr = clr; v.chk_rdy = chk_rdy;
        v.rdy = rdy; v.ld = ld; v.sh = s;
        v.dat = dat; v.uf = uf;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, want %h",
                     nm, $time, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ld,
                            input logic [3:0] s,
                            input logic [15:0] dat,
                            input logic uf);
        chk({tag, ".load"}, 16'(load_o), 16'(ld));
        chk({tag, ".shift"}, 16'(sh), 16'(s));
        chk({tag, ".dat"}, dat_o, dat);
        chk({tag, ".uflow"}, 16'(underflow_o), 16'(uf));
    endtask

    task automatic edge_step;
        @(posedge clk);
        #1;
    endtask

    vec_t tv [17];

    initial begin
        reset_i = 1'b1; bpp_i = 2'b11; active_i = 1'b1;
        word_dat_i = 16'h1234; word_valid_i = 1'b1;
        flush_i = 1'b0; clr_underflow_i = 1'b0;

        //            rst bpp act vld wd        fl clr ck rdy ld sh     dat       uf
        tv[0]  = mk(1, 3, 1, 1, 16'h1234, 0, 0, 0, 0, 0, 4'h0, 16'h0000, 0);
        tv[1]  = mk(1, 3, 1, 1, 16'h1234, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 0);
        tv[2]  = mk(0, 3, 0, 1, 16'h1234, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 0);
        tv[3]  = mk(0, 3, 0, 1, 16'h5678, 0, 0, 1, 0, 0, 4'h0, 16'h0000, 0);
        tv[4]  = mk(0, 3, 1, 1, 16'h5678, 0, 0, 1, 1, 1, 4'h0, 16'h1234, 0);
        tv[5]  = mk(0, 3, 1, 1, 16'h9ABC, 0, 0, 1, 0, 0, 4'h8, 16'h1234, 0);
        tv[6]  = mk(0, 3, 1, 1, 16'h9ABC, 0, 0, 1, 1, 1, 4'h0, 16'h5678, 0);
        tv[7]  = mk(0, 3, 1, 0, 16'h0000, 0, 0, 1, 0, 0, 4'h8, 16'h5678, 0);
        tv[8]  = mk(0, 3, 1, 0, 16'h0000, 0, 0, 1, 1, 1, 4'h0, 16'h9ABC, 0);
        tv[9]  = mk(0, 3, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 4'h8, 16'h9ABC, 0);
        tv[10] = mk(0, 3, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 4'h0, 16'h9ABC, 0);
        tv[11] = mk(0, 3, 1, 0, 16'h0000, 0, 0, 1, 1, 1, 4'h0, 16'h0000, 1);
        tv[12] = mk(0, 3, 1, 0, 16'h0000, 0, 0, 1, 1, 0, 4'h8, 16'h0000, 1);
        tv[13] = mk(0, 3, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 4'h0, 16'h0000, 0);
        tv[14] = mk(0, 3, 1, 0, 16'h0000, 0, 1, 1, 1, 1, 4'h0, 16'h0000, 1);
        tv[15] = mk(0, 3, 0, 0, 16'h0000, 0, 0, 1, 1, 0, 4'h0, 16'h0000, 1);
        tv[16] = mk(0, 3, 0, 0, 16'h0000, 0, 1, 1, 1, 0, 4'h0, 16'h0000, 0);

        for (int i = 0; i < 17; i++) begin
            reset_i = tv[i].rst; bpp_i = tv[i].bpp;
            active_i = tv[i].act; word_valid_i = tv[i].vld;
            word_dat_i = tv[i].wd; flush_i = tv[i].fl;
            clr_underflow_i = tv[i].clr;
            #1;
            if (tv[i].chk_rdy)
                chk($sformatf("tv%0d.ready", i),
                    16'(word_ready_o), 16'(tv[i].rdy));
            edge_step();
            chk_outs($sformatf("tv%0d", i), tv[i].ld,
                     tv[i].sh, tv[i].dat, tv[i].uf);
        end

        // 1bpp: preload AAAA, then 17 visible edges
        bpp_i = 2'b00; active_i = 1'b0; clr_underflow_i = 1'b0;
        word_valid_i = 1'b1; word_dat_i = 16'hAAAA;
        #1;
        chk("bpp1.preload_ready", 16'(word_ready_o), 16'h1);
        edge_step();
        active_i = 1'b1; word_dat_i = 16'h5555;
        for (int k = 0; k < 17; k++) begin
            edge_step();
            if (k == 0 || k == 16)
                chk_outs($sformatf("bpp1.e%0d", k), 1'b1, 4'h0,
                         (k == 0) ? 16'hAAAA : 16'h5555, 1'b0);
            else
                chk_outs($sformatf("bpp1.e%0d", k), 1'b0, 4'h1,
                         16'hAAAA, 1'b0);
        end

        // depth latch: line at 2bpp, input moved to 8bpp mid-line
        active_i = 1'b0; bpp_i = 2'b01; word_valid_i = 1'b0;
        edge_step();
        chk_outs("gap1", 1'b0, 4'h0, 16'h5555, 1'b0);
        active_i = 1'b1; word_valid_i = 1'b1; word_dat_i = 16'h1111;
        for (int k = 0; k < 24; k++) begin
            edge_step();
            bpp_i = 2'b11;
            chk_outs($sformatf("bpp2.e%0d", k), (k % 8) == 0,
                     ((k % 8) == 0) ? 4'h0 : 4'h2,
                     (k < 8) ? 16'h5555 : 16'h1111, 1'b0);
        end
        active_i = 1'b0;
        edge_step();
        chk_outs("gap2", 1'b0, 4'h0, 16'h1111, 1'b0);
        active_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            edge_step();
            chk_outs($sformatf("bpp8.e%0d", k), (k % 2) == 0,
                     ((k % 2) == 0) ? 4'h0 : 4'h8,
                     16'h1111, 1'b0);
        end

        // flush a full buffer, then the next line underflows
        active_i = 1'b0; word_valid_i = 1'b0; flush_i = 1'b1;
        #1;
        chk("flush.ready", 16'(word_ready_o), 16'h0);
        edge_step();
        chk_outs("flush", 1'b0, 4'h0, 16'h1111, 1'b0);
        flush_i = 1'b0; active_i = 1'b1;
        #1;
        chk("postflush.ready", 16'(word_ready_o), 16'h1);
        edge_step();
        chk_outs("flush.load", 1'b1, 4'h0, 16'h0000, 1'b1);
        edge_step();
        chk_outs("flush.shift", 1'b0, 4'h8, 16'h0000, 1'b1);

        // reset in the middle of a visible line
        reset_i = 1'b1; word_valid_i = 1'b1; word_dat_i = 16'hBEEF;
        edge_step();
        chk_outs("midrst", 1'b0, 4'h0, 16'h0000, 1'b0);
        reset_i = 1'b0; active_i = 1'b0; word_valid_i = 1'b0;
        #1;
        chk("midrst.ready", 16'(word_ready_o), 16'h1);
        edge_step();
        chk_outs("idle", 1'b0, 4'h0, 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have the port dotclk_i  input  1  dot clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port reset_i  input  1  reset; synchronous, active-high.
REQ-003 The block SHALL have the port bpp_i  input  2  depth select: 00=1bpp, 01=2bpp, 10=4bpp, 11=8bpp.
REQ-004 The block SHALL have the port active_i  input  1  high during the visible part of a scan line.
REQ-005 The block SHALL have the port word_dat_i  input  16  pixel word from the fetch FIFO.
REQ-006 The block SHALL have the port word_valid_i  input  1  word_dat_i holds a valid word.
REQ-007 The block SHALL have the port word_ready_o  output  1  the block accepts word_dat_i this cycle.
REQ-008 The block SHALL have the port flush_i  input  1  discard the buffered word.
REQ-009 The block SHALL have the port clr_underflow_i  input  1  clear the underflow flag.
REQ-010 The block SHALL have the ports dat_o (output, 16), load_o (output, 1), shift1_o, shift2_o, shift4_o and shift8_o (outputs, 1 each); together they drive the shifter's dat_i, load_i and shiftN_i.
REQ-011 The block SHALL have the port underflow_o  output  1  sticky flag: a load found no word.

Function
REQ-012 Words per line SHALL flow as follows: one-word holding buffer (buf, buf_full), then pixel counter pix_cnt (4 bits), then registered shifter controls.
REQ-013 A word transfer SHALL occur on every rising edge where word_valid_i and word_ready_o are both 1.
REQ-014 word_ready_o SHALL be combinational: ~buf_full | load_now, where load_now = (state==RUN or the IDLE->RUN edge) & active_i & pix_cnt==0 & buf_full.
REQ-015 Pixels per word SHALL be PPW = 16 >> bpp_lat, giving 16/8/4/2 pixels.
REQ-016 bpp_lat SHALL load from bpp_i on every cycle where active_i=0, and SHALL hold while active_i=1, so that depth changes mid-line are ignored.
REQ-017 The state machine SHALL have two states: IDLE and RUN.
REQ-018 IDLE->RUN SHALL occur on any edge with active_i=1; RUN->IDLE SHALL occur on any edge with active_i=0.
REQ-019 On an edge with active_i=0, the block SHALL register load_o=0 and all shiftN_o=0, and SHALL set pix_cnt=0.
REQ-020 On an edge with active_i=1 and pix_cnt==0, the block SHALL register load_o=1, dat_o=buf and all shiftN_o=0, and SHALL set pix_cnt=PPW-1 and buf_full=0, unless a new word is accepted on the same edge.
REQ-021 If pix_cnt==0 and buf_full=0 under active_i=1 (underflow), the block SHALL register load_o=1 and dat_o=16'h0000, SHALL set pix_cnt=PPW-1, and SHALL set underflow_o=1.
REQ-022 On an edge with active_i=1 and pix_cnt!=0, the block SHALL register load_o=0, shiftN_o=1 for the latched depth only (the others 0), and pix_cnt-1, while dat_o holds its value.
REQ-023 load_o and every shiftN_o SHALL be mutually exclusive; at most one of the five is 1 in any cycle.
REQ-024 Latency: controls SHALL be registered, so the shifter acts one edge after the sequencer decides; the first load of a line is visible at load_o one cycle after active_i rises.
REQ-025 Simultaneous accept and consume: the new word SHALL enter buf and buf_full SHALL stay 1.
REQ-026 flush_i SHALL set buf_full=0 and has priority over an accept on the same edge; word_ready_o SHALL be 0 while flush_i=1.
REQ-027 underflow_o SHALL stay 1 until clr_underflow_i=1 or reset; if set and clear occur on the same edge, set wins.
REQ-028 buf SHALL be retained across active_i=0, since it is the prefetch for the next line; a partially shown word SHALL be discarded at the end of the line.

Reset
REQ-029 While reset_i=1 at an edge, the block SHALL set state=IDLE, pix_cnt=0, buf_full=0, buf=0, bpp_lat=00, dat_o=0000, load_o=0, all shiftN_o=0 and underflow_o=0.
REQ-030 Reset SHALL override all other inputs, including during a line (RUN) with active_i=1.
REQ-031 After reset is released, word_ready_o SHALL be 1.

Verification
REQ-032 Reset: hold reset_i for 2 edges with active_i=1 and word_valid_i=1 -> all outputs 0, buf empty; first edge after release accepts the word.
REQ-033 1bpp: preload AAAA, bpp_i=00, active_i=1 for 17 edges with 5555 offered -> load_o=1 with dat_o=AAAA once, then shift1_o=1 for 15 cycles, then load_o=1 with dat_o=5555.
REQ-034 8bpp streaming: bpp_i=11, words 1234, 5678, 9ABC valid back-to-back -> load/shift8/load/shift8/load pattern, dat_o=1234 then 5678 then 9ABC, word_ready_o=1 on each load cycle, underflow_o stays 0.
REQ-035 Underflow: buf empty when active_i rises -> load_o=1, dat_o=0000, underflow_o=1 and held; pulse clr_underflow_i -> 0.
REQ-036 Depth latch: bpp_i=01 at line start, changed to 11 mid-line -> shift2_o pattern (load every 8 cycles) until active_i falls; the next line uses shift8_o.
REQ-037 Flush plus reset in RUN: flush_i with buf full -> next load underflows with dat_o=0000; reset_i mid-line -> controls 0 on the next cycle.
